camera_ray_gen: RTL

Per-frame primary-ray generator that feeds the ray-sphere intersection pipeline. On a start pulse it scans the screen in raster order and emits one ray per accepted cycle. Each ray carries a Q8.8 origin, a Q8.8 direction and its pixel coordinates. Directions are built incrementally by add/subtract, with no multipliers, and outputs map 1:1 onto the intersector's `valid_in` and ray inputs; pixel coordinates travel alongside for the shading/write-back path.

---
 rtl/camera_ray_gen_if.sv | 26 ++
 rtl/camera_ray_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/camera_ray_gen_if.sv
// rtl/camera_ray_gen_if.sv - ray bundle from the camera ray generator to the intersector
interface camera_ray_gen_if #(
  parameter int PX_W = 6,
  parameter int PY_W = 6
);
  logic               valid_out;
  logic signed [15:0] ray_origin_x;
  logic signed [15:0] ray_origin_y;
  logic signed [15:0] ray_origin_z;
  logic signed [15:0] ray_dir_x;
  logic signed [15:0] ray_dir_y;
  logic signed [15:0] ray_dir_z;
  logic [PX_W-1:0]    pixel_x;
  logic [PY_W-1:0]    pixel_y;
  logic               last_pixel;

  modport master (
    output valid_out, ray_origin_x, ray_origin_y, ray_origin_z,
    output ray_dir_x, ray_dir_y, ray_dir_z, pixel_x, pixel_y, last_pixel
  );

  modport slave (
    input valid_out, ray_origin_x, ray_origin_y, ray_origin_z,
    input ray_dir_x, ray_dir_y, ray_dir_z, pixel_x, pixel_y, last_pixel
  );
endinterface

// File: rtl/camera_ray_gen.sv
// rtl/camera_ray_gen.sv - raster-order primary ray generator, Q8.8 directions by add/subtract only
module camera_ray_gen #(
  parameter int                 H_RES  = 64,
  parameter int                 V_RES  = 48,
  parameter logic signed [15:0] STEP_X = 16'sd8,
  parameter logic signed [15:0] STEP_Y = 16'sd8,
  parameter logic signed [15:0] FOCAL  = 16'sd256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic signed [15:0] cam_x,
  input  logic signed [15:0] cam_y,
  input  logic signed [15:0] cam_z,
  camera_ray_gen_if.master   ray,
  output logic               busy,
  output logic               frame_done
);
  localparam int PXW = $clog2(H_RES);
  localparam int PYW = $clog2(V_RES);
  localparam logic signed [15:0] DX_INIT = 16'(-(H_RES / 2) * STEP_X);
  localparam logic signed [15:0] DY_INIT = 16'((V_RES / 2) * STEP_Y);
  localparam logic [PXW-1:0]     PX_LAST = PXW'(H_RES - 1);
  localparam logic [PYW-1:0]     PY_LAST = PYW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [PXW-1:0]     px;
  logic [PYW-1:0]     py;
  logic signed [15:0] dx_acc, dy_acc;
  logic signed [15:0] cam_lx, cam_ly, cam_lz;
  logic               emit, line_end, emit_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (emit_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    emit      = (state == RUN) && !stall;
    line_end  = (px == PX_LAST);
    emit_last = emit && line_end && (py == PY_LAST);
  end

  // Everything leaving the block is a flop; stalled edges freeze the ray and the scan position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px               <= '0;
      py               <= '0;
      dx_acc           <= '0;
      dy_acc           <= '0;
      cam_lx           <= '0;
      cam_ly           <= '0;
      cam_lz           <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      ray.valid_out    <= 1'b0;
      ray.last_pixel   <= 1'b0;
      ray.ray_origin_x <= '0;
      ray.ray_origin_y <= '0;
      ray.ray_origin_z <= '0;
      ray.ray_dir_x    <= '0;
      ray.ray_dir_y    <= '0;
      ray.ray_dir_z    <= '0;
      ray.pixel_x      <= '0;
      ray.pixel_y      <= '0;
    end else begin
      busy           <= (state_nx != IDLE);
      frame_done     <= (state == DONE);
      ray.valid_out  <= emit;
      ray.last_pixel <= emit_last;

      if (state == IDLE && start) begin
        cam_lx <= cam_x;
        cam_ly <= cam_y;
        cam_lz <= cam_z;
        px     <= '0;
        py     <= '0;
        dx_acc <= DX_INIT;
        dy_acc <= DY_INIT;
      end

      if (emit) begin
        ray.ray_origin_x <= cam_lx;
        ray.ray_origin_y <= cam_ly;
        ray.ray_origin_z <= cam_lz;
        ray.ray_dir_x    <= dx_acc;
        ray.ray_dir_y    <= dy_acc;
        ray.ray_dir_z    <= FOCAL;
        ray.pixel_x      <= px;
        ray.pixel_y      <= py;
        if (!line_end) begin
          px     <= px + 1'b1;
          dx_acc <= dx_acc + STEP_X;
        end else begin
          px     <= '0;
          dx_acc <= DX_INIT;
          py     <= py + 1'b1;
          dy_acc <= dy_acc - STEP_Y;
        end
      end
    end
  end
endmodule
